// File: rtl/regfile_mp.sv
// regfile_mp: NWR-write/NRD-read register file with x0 hardwired, write bypass and post-reset clear sweep.
// Defining REGFILE_SCOREBOARD_EN adds per-register pending bits (iss_en/iss_addr in, rd_busy out).
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  output logic                 ready,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic [NRD-1:0]       rd_busy,
`endif
  output logic [NRD*XLEN-1:0]  rd_data
);
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] init_idx_q, init_idx_d;
  logic ready_q, ready_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [AW-1:0] wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0] we;
  assign ready = ready_q;
  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wa[i] = wr_addr[i*AW +: AW];
    assign wd[i] = wr_data[i*XLEN +: XLEN];
    assign we[i] = wr_en[i] & ready_q & ~halt & (wa[i] != '0);
  end
  always_comb begin
    state_d = state_q;
    init_idx_d = init_idx_q;
    ready_d = ready_q;
    if (state_q == INIT) begin
      init_idx_d = init_idx_q + 1'b1;
      if (init_idx_q == AW'(NREGS - 1)) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      init_idx_q <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_idx_q <= init_idx_d;
      ready_q <= ready_d;
    end
  end
  // x0 is never stored; the sweep starts at 1 and x0 writes never reach here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) mem_q[init_idx_q] <= '0;
      else
        for (int i = NWR - 1; i >= 0; i--)
          if (we[i]) mem_q[wa[i]] <= wd[i];
    end
  end
`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] sb_q, sb_d;
  always_comb begin
    sb_d = sb_q;
    for (int i = 0; i < NWR; i++)
      if (we[i]) sb_d[wa[i]] = 1'b0;
    if (iss_en && ready_q && !halt && iss_addr != '0) sb_d[iss_addr] = 1'b1;
  end
  always_ff @(posedge clk) sb_q <= (reset || state_q == INIT) ? '0 : sb_d;
`endif
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] ra;
    logic [NWR-1:0] hit;
    logic [XLEN-1:0] val;
    assign ra = rd_addr[j*AW +: AW];
    // Descending scan so the lowest-index matching port lands last and wins.
    always_comb begin
      hit = '0;
      val = mem_q[ra];
      for (int i = NWR - 1; i >= 0; i--) begin
        hit[i] = we[i] && (wa[i] == ra);
        if (hit[i]) val = wd[i];
      end
      if (ra == '0 || !ready_q) val = '0;
    end
    assign rd_data[j*XLEN +: XLEN] = val;
`ifdef REGFILE_SCOREBOARD_EN
    assign rd_busy[j] = sb_q[ra] & ~|hit & (ra != '0);
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random stimulus checked against an array-based model of the register file.
module tb_regfile_mp;
  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;
  logic clk = 1'b0, reset = 1'b1, halt = 1'b0;
  logic ready;
  logic [NWR-1:0] wr_en = '0;
  logic [NWR*AW-1:0] wr_addr = '0;
  logic [NWR*XLEN-1:0] wr_data = '0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
`ifdef REGFILE_SCOREBOARD_EN
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [NRD-1:0] rd_busy;
`endif
  always #5 clk = ~clk;
  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .reset(reset), .halt(halt), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
`ifdef REGFILE_SCOREBOARD_EN
    .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy),
`endif
    .rd_data(rd_data)
  );
  int n_chk = 0, n_fail = 0;
  logic [XLEN-1:0] ref_mem [NREGS];
  bit ref_ready = 1'b0;
  int ref_cnt = 0;
  bit ref_sb [NREGS];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic bit eff(input int i);
    return wr_en[i] && ref_ready && !halt && wr_addr[i*AW +: AW] != '0;
  endfunction
  function automatic logic [XLEN-1:0] exp_rd(input int a, output bit hit);
    hit = 1'b0;
    if (a == 0 || !ref_ready) return '0;
    for (int i = 0; i < NWR; i++)
      if (eff(i) && int'(wr_addr[i*AW +: AW]) == a) begin
        hit = 1'b1;
        return wr_data[i*XLEN +: XLEN];
      end
    return ref_mem[a];
  endfunction
  task automatic check_outputs();
    bit hit;
    int a;
    logic [XLEN-1:0] e;
    chk("ready", {63'd0, ready}, {63'd0, ref_ready});
    for (int j = 0; j < NRD; j++) begin
      a = int'(rd_addr[j*AW +: AW]);
      e = exp_rd(a, hit);
      chk($sformatf("rd%0d_x%0d", j, a), {32'd0, rd_data[j*XLEN +: XLEN]}, {32'd0, e});
`ifdef REGFILE_SCOREBOARD_EN
      chk($sformatf("busy%0d_x%0d", j, a), {63'd0, rd_busy[j]}, {63'd0, ref_sb[a] && a != 0 && !hit});
`endif
    end
  endtask
  task automatic update_model();
    bit e [NWR];
    if (reset) begin
      ref_ready = 1'b0;
      ref_cnt = 0;
      foreach (ref_sb[k]) ref_sb[k] = 1'b0;
    end else if (!ref_ready) begin
      ref_cnt++;
      if (ref_cnt == NREGS - 1) begin
        ref_ready = 1'b1;
        foreach (ref_mem[k]) ref_mem[k] = '0;
      end
    end else begin
      for (int i = 0; i < NWR; i++) e[i] = eff(i);
      for (int i = NWR - 1; i >= 0; i--)
        if (e[i]) begin
          ref_mem[wr_addr[i*AW +: AW]] = wr_data[i*XLEN +: XLEN];
          ref_sb[wr_addr[i*AW +: AW]] = 1'b0;
        end
`ifdef REGFILE_SCOREBOARD_EN
      if (iss_en && !halt && iss_addr != '0) ref_sb[iss_addr] = 1'b1;
`endif
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask
  task automatic set_wr(input int p, input bit en, input int a, input logic [XLEN-1:0] d);
    wr_en[p] = en;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask
  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask
  task automatic peek(input string tag, input int p, input logic [XLEN-1:0] exp);
    #1;
    chk(tag, {32'd0, rd_data[p*XLEN +: XLEN]}, {32'd0, exp});
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(n), 64'(NREGS - 1));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    foreach (ref_sb[k]) ref_sb[k] = 1'b0;
    foreach (ref_mem[k]) ref_mem[k] = '0;
    @(posedge clk);
    update_model();
    #1;
    tick();
    reset = 1'b0;
    wait_ready("ready_lat_first");
    set_wr(0, 1, 5, 32'hDEAD);
    tick();
    set_wr(0, 0, 0, '0);
    set_rd(0, 5);
    peek("x5_preload", 0, 32'hDEAD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("ready_lat_sweep");
    peek("x5_cleared", 0, '0);
    for (int a = 0; a < NREGS; a++) begin
      set_rd(a % NRD, a);
      peek($sformatf("clr_x%0d", a), a % NRD, '0);
    end
    set_wr(1, 1, 3, 32'h12345678);
    set_rd(0, 3);
    peek("x3_bypass", 0, 32'h12345678);
    tick();
    set_wr(1, 0, 0, '0);
    peek("x3_commit", 0, 32'h12345678);
    set_wr(0, 1, 7, 32'hAAAA0000);
    set_wr(1, 1, 7, 32'h5555FFFF);
    set_rd(0, 7);
    peek("x7_bypass_prio", 0, 32'hAAAA0000);
    tick();
    set_wr(0, 0, 0, '0);
    set_wr(1, 0, 0, '0);
    peek("x7_commit_prio", 0, 32'hAAAA0000);
    set_wr(0, 1, 7, 32'hBBBB0000);
    set_wr(1, 1, 8, 32'h1);
    tick();
    set_wr(0, 0, 0, '0);
    set_wr(1, 0, 0, '0);
    set_rd(1, 8);
    peek("x7_distinct", 0, 32'hBBBB0000);
    peek("x8_distinct", 1, 32'h1);
    set_wr(0, 1, 0, 32'hFFFFFFFF);
    set_rd(0, 0);
    peek("x0_bypass", 0, '0);
    tick();
    set_wr(0, 0, 0, '0);
    peek("x0_commit", 0, '0);
    halt = 1'b1;
    set_wr(0, 1, 9, 32'h42);
    set_rd(0, 9);
    peek("x9_halt_read", 0, '0);
    tick();
    halt = 1'b0;
    set_wr(0, 0, 0, '0);
    peek("x9_after_halt", 0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_wr(0, 1, $urandom_range(1, NREGS - 1), $urandom);
      set_wr(1, 1, $urandom_range(1, NREGS - 1), $urandom);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready("ready_lat_restart");
    set_wr(0, 0, 0, '0);
    set_wr(1, 0, 0, '0);
    for (int a = 1; a < NREGS; a += 3) begin
      set_rd(0, a);
      peek($sformatf("init_wr_x%0d", a), 0, '0);
    end
`ifdef REGFILE_SCOREBOARD_EN
    iss_en = 1'b1;
    iss_addr = 4;
    set_rd(0, 4);
    tick();
    iss_en = 1'b0;
    #1;
    chk("sb_busy_set", {63'd0, rd_busy[0]}, 64'd1);
    set_wr(1, 1, 4, 32'h99);
    peek("sb_wr_bypass", 0, 32'h99);
    chk("sb_busy_bypass", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    set_wr(1, 0, 0, '0);
    #1;
    chk("sb_busy_cleared", {63'd0, rd_busy[0]}, 64'd0);
    iss_en = 1'b1;
    set_wr(1, 1, 4, 32'h77);
    tick();
    iss_en = 1'b0;
    set_wr(1, 0, 0, '0);
    #1;
    chk("sb_set_wins", {63'd0, rd_busy[0]}, 64'd1);
`endif
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NWR; i++)
        set_wr(i, $urandom_range(0, 3) != 0, (c & 1) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1), $urandom);
      for (int j = 0; j < NRD; j++) set_rd(j, (c & 2) ? $urandom_range(0, 7) : $urandom_range(0, NREGS - 1));
      halt = $urandom_range(0, 9) == 0;
`ifdef REGFILE_SCOREBOARD_EN
      iss_en = $urandom_range(0, 2) == 0;
      iss_addr = AW'($urandom_range(0, 7));
`endif
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core. It generalises the two-write/two-read write-back register file to NWR write ports and NRD read ports.
- Write ports have fixed priority. Reads forward same-cycle write data combinationally, and x0 is hardwired to zero.
- After reset, a sequential clear sweep zeroes the array, so no wide single-cycle reset fanout is needed. A `ready` flag gates the rest of the pipeline.
- Sits between decode (read side) and the EX/MEM result buses (write side).

Parameters:
- XLEN, 32, data width of every register.
- NREGS, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; port 0 is the youngest stage and has the highest priority.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- halt  in  1  suppresses all architectural writes while high.
- ready  out  1  high once the clear sweep has finished.
- wr_en  in  NWR  per-port write request.
- wr_addr  in  NWR*AW  flattened write addresses; port i uses bits [i*AW +: AW].
- wr_data  in  NWR*XLEN  flattened write data.
- rd_addr  in  NRD*AW  flattened read addresses.
- rd_data  out  NRD*XLEN  flattened read data (combinational).

Behaviour:
- State machine: INIT and RUN.
  - Reset high: state <= INIT, init_idx <= 1, ready <= 0. Array contents are not modified in that cycle.
  - INIT, reset low: reg[init_idx] <= 0, then init_idx <= init_idx+1. When init_idx == NREGS-1, state <= RUN and ready <= 1.
  - ready therefore rises on the (NREGS-1)th rising edge after reset deasserts, i.e. 31 cycles for the defaults.
  - Reset asserted mid-sweep restarts the sweep from index 1.
  - RUN is left only via reset.
- Effective write enable: we_i = wr_en[i] & ready & ~halt & (wr_addr_i != 0).
  - Writes to x0 are discarded.
  - All wr_en inputs are ignored during INIT and while halt is high.
- Write conflict: when several we_i target the same address, the lowest index wins. The array update happens on the rising edge.
- Writes to distinct addresses in the same cycle all commit.
- Read, per port j, in priority order:
  - rd_addr == 0 → 0.
  - Else if !ready → 0.
  - Else if any we_i with wr_addr_i == rd_addr → wr_data of the lowest such i (bypass).
  - Else → reg[rd_addr].
- Bypass uses effective enables, so no forwarding occurs during halt. This keeps the read value consistent with the architectural state.
- Registers at or beyond NREGS are unreachable because AW is exact. There are no out-of-range cases.
- No output other than `ready` is registered. rd_data is a pure function of the current inputs and state.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: adds the following ports.
  - iss_en in 1 and iss_addr in AW: mark a destination pending.
  - rd_busy out NRD: per read port, the pending bit of rd_addr.
- Pending bits array sb[NREGS]:
  - Cleared by reset and held clear during INIT.
  - Set on an edge when iss_en & ready & ~halt & iss_addr != 0.
  - Cleared by any effective write to that address.
  - Simultaneous issue and write to the same address: set wins.
- rd_busy_j = sb[rd_addr_j] & ~(bypass hit on port j). It is 0 for x0.
- Not defined: no extra ports, no sb storage; behaviour is identical otherwise.

Test Plan:
- Reset sweep: preload x5=0xDEAD via a write, pulse reset 1 cycle, then hold wr_en=0. Required: ready low for exactly 31 cycles, then high; x5 reads 0; all registers read 0.
- Write/read: after ready, write x3=0x12345678 on port 1. Next cycle read rd_addr0=3. Required: 0x12345678; same-cycle read of 3 returns the bypassed 0x12345678.
- Priority conflict: same cycle, port0 x7=0xAAAA0000 and port1 x7=0x5555FFFF. Required: bypass and the committed value are both 0xAAAA0000; simultaneous port1 write to x8=0x1 also commits.
- x0 and halt:
  - Write x0=0xFFFFFFFF. Required: reads 0.
  - With halt=1, write x9=0x42. Required: rd_data shows the old x9 (0), and x9 is still 0 after halt drops.
- Reset mid-sweep: assert reset at sweep cycle 10, release. Required: ready rises exactly 31 cycles after the second release; writes issued during INIT have no effect.
- (REGFILE_SCOREBOARD_EN) Issue x4. Required: rd_busy=1 when reading 4.
  - Write x4=0x99 via port 1. Required: same cycle rd_busy=0 with rd_data=0x99; next cycle sb[4] clear.
  - Issue and write x4 together. Required: busy remains set.
